control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, the only clock; every state change happens on its rising edge.
REQ-002 SHALL have port Reset, input, 1, a synchronous, active-high reset sampled on the Clock rising edge.
REQ-003 SHALL have port IR, input, 32, the instruction register contents; opcode = IR[31:27].
REQ-004 SHALL have port CON, input, 1, the branch-condition flag from the datapath CON flip-flop.
REQ-005 SHALL have port Stop, input, 1, a halt request, sampled only in state T0.
REQ-006 SHALL have port in_en, output, 10, the packed register loads {HIin,LOin,PCin,MDRin,INPORTin,Zin,Yin,MARin,IRin,CONin}, MSB first.
REQ-007 SHALL have port out_en, output, 10, the packed bus drives {HIout,LOout,ZHIout,ZLOout,PCout,MDRout,INPORTout,OUTPORTout,Cout,Yout}, MSB first.
REQ-008 SHALL have port gsel, output, 6, the packed register-select signals {Gra,Grb,Grc,Rin,Rout,BAout}.
REQ-009 SHALL have ports Read, write and IncPC, each an output of width 1, driving the memory read strobe, memory write strobe and PC increment.
REQ-010 SHALL have port Run, output, 1, which is 1 while the controller is sequencing instructions.
REQ-011 SHALL have port step, output, 4, the current T-step number (0 = T0); it reads 15 in IDLE, HALT and ILLEGAL.
REQ-012 SHALL have port illegal, output, 1, the unknown-opcode flag (see REQ-027).

Function
REQ-013 SHALL be a Moore machine with states IDLE, T0–T7, HALT and ILLEGAL; all outputs SHALL be decoded from the state register and IR only, and exactly one step SHALL occur per clock.
REQ-014 SHALL move from IDLE to T0 on the next edge; in IDLE all strobes SHALL be 0 and Run SHALL be 1.
REQ-015 SHALL perform fetch as follows:
- T0: PCout, MARin, IncPC, Zin.
- T1: ZLOout, PCin, Read, MDRin.
- T2: MDRout, IRin.
REQ-016 SHALL execute ld (00000) as follows:
- T3: Grb, BAout, Yin.
- T4: Cout, Zin.
- T5: ZLOout, MARin.
- T6: Read, MDRin.
- T7: MDRout, Gra, Rin; then go to T0.
REQ-017 SHALL execute ldi (00001) with the ld T3 and T4 steps, then T5: ZLOout, Gra, Rin; then go to T0.
REQ-018 SHALL execute st (00010) as follows:
- T3–T5: same as ld.
- T6: Gra, Rout, MDRin.
- T7: write; then go to T0.
REQ-019 SHALL execute addi/andi/ori (01100/01101/01110) as follows:
- T3: Grb, Rout, Yin.
- T4: Cout, Zin.
- T5: ZLOout, Gra, Rin; then go to T0.
REQ-020 SHALL execute br (10010) as follows:
- T3: Gra, Rout, CONin.
- T4: PCout, Yin.
- T5: Cout, Zin.
- T6: if CON=1, ZLOout and PCin; if CON=0, no strobes. Then go to T0.
- CON SHALL be sampled combinationally in T6, never in an earlier step.
REQ-021 SHALL execute in (10101) as T3: INPORTout, Gra, Rin; then go to T0.
REQ-022 SHALL execute nop (11001) by going from T2 directly to T0.
REQ-023 SHALL execute halt (11010) by going from T2 to HALT; in HALT, Run=0, all strobes are 0, and the state is held until Reset.
REQ-024 SHALL, when Stop=1 in T0, complete T0 and then go to HALT instead of T1.
REQ-025 SHALL never assert write and Read in the same cycle, and SHALL never assert more than one out_en bit in the same cycle.

Reset
REQ-026 SHALL, on any edge with Reset=1, force the state to IDLE with all strobes at 0, Run=1, illegal=0 and step=15, regardless of the current state (including mid-instruction, HALT or ILLEGAL); the T-step in progress SHALL be abandoned, and no write SHALL occur in the cycle after reset.

Configuration
REQ-027 SHALL support macro ILLEGAL_TRAP_EN:
- Defined: an unlisted opcode in T2 SHALL go to ILLEGAL, where Run=0, illegal=1 and all strobes are 0, held until Reset.
- Undefined: an unlisted opcode SHALL behave as nop, and illegal SHALL be tied to 0.

Verification
REQ-028 SHALL cover: Reset for 2 cycles then release -> IDLE for 1 cycle, then T0 with out_en=PCout only, in_en=MARin|Zin, and IncPC=1.
REQ-029 SHALL cover: IR=ld (opcode 00000) -> 8 cycles T0–T7, Read asserted in T1 and T6, and Gra+Rin in T7.
REQ-030 SHALL cover: br with CON=0 -> no PCin in T6; br with CON=1 -> ZLOout and PCin in T6; the next T0 follows in both cases.
REQ-031 SHALL cover: st -> write=1 only in T7, with Read=0 in that cycle.
REQ-032 SHALL cover: Stop=1 during T0 -> HALT next cycle with Run=0; Reset asserted in T4 of ld -> IDLE with all strobes 0 next cycle.
REQ-033 SHALL cover: opcode 11111 -> ILLEGAL with illegal=1 when ILLEGAL_TRAP_EN is defined; behaves as nop (returns to T0) when it is undefined.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: Moore-style micro-sequencer for a 32-bit load/store CPU.
// Steps through IDLE -> T0..T7 per instruction. It also has HALT and ILLEGAL
// stop states. Outputs are decoded from the state register and IR. CON is also
// used in T6 of br.
//
// Ports
//   Clock     in   1   only clock, rising edge
//   Reset     in   1   synchronous active-high reset -> IDLE
//   IR        in  32   instruction register, opcode = IR[31:27]
//   CON       in   1   branch condition flag
//   Stop      in   1   halt request, honoured in T0 only
//   in_en     out 10   {HIin,LOin,PCin,MDRin,INPORTin,Zin,Yin,MARin,IRin,CONin}
//   out_en    out 10   {HIout,LOout,ZHIout,ZLOout,PCout,MDRout,INPORTout,OUTPORTout,Cout,Yout}
//   gsel      out  6   {Gra,Grb,Grc,Rin,Rout,BAout}
//   Read      out  1   memory read strobe
//   write     out  1   memory write strobe
//   IncPC     out  1   PC increment
//   Run       out  1   low in HALT / ILLEGAL
//   step      out  4   current T-step, 15 outside T0..T7
//   illegal   out  1   unknown-opcode trap flag
//
// Optional feature macro: ILLEGAL_TRAP_EN (trap unknown opcodes into ILLEGAL).
module control_sequencer (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] IR,
   input  logic        CON,
   input  logic        Stop,
   output logic [9:0]  in_en,
   output logic [9:0]  out_en,
   output logic [5:0]  gsel,
   output logic        Read,
   output logic        write,
   output logic        IncPC,
   output logic        Run,
   output logic [3:0]  step,
   output logic        illegal
);

   localparam int unsigned OPC_W = 5;

   localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
   localparam logic [OPC_W-1:0] OP_IN   = 5'b10101;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

   // bit positions inside the packed strobe buses
   localparam int unsigned IN_PC    = 7;
   localparam int unsigned IN_MDR   = 6;
   localparam int unsigned IN_INP   = 5;
   localparam int unsigned IN_Z     = 4;
   localparam int unsigned IN_Y     = 3;
   localparam int unsigned IN_MAR   = 2;
   localparam int unsigned IN_IR    = 1;
   localparam int unsigned IN_CON   = 0;
   localparam int unsigned OUT_ZLO  = 6;
   localparam int unsigned OUT_PC   = 5;
   localparam int unsigned OUT_MDR  = 4;
   localparam int unsigned OUT_INP  = 3;
   localparam int unsigned OUT_C    = 1;
   localparam int unsigned G_RA     = 5;
   localparam int unsigned G_RB     = 4;
   localparam int unsigned G_RIN    = 2;
   localparam int unsigned G_ROUT   = 1;
   localparam int unsigned G_BA     = 0;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_ILLEGAL
   } state_t;

   state_t            state_q, state_d;
   logic [OPC_W-1:0]  opcode;
   logic              unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   // state register
   always_ff @(posedge Clock) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: state_d = S_T0;
         S_T0:   state_d = Stop ? S_HALT : S_T1;
         S_T1:   state_d = S_T2;
         S_T2: begin
            case (opcode)
               OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_IN:
                  state_d = S_T3;
               OP_NOP:  state_d = S_T0;
               OP_HALT: state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
               default: state_d = S_ILLEGAL;
`else
               default: state_d = S_T0;
`endif
            endcase
         end
         S_T3: state_d = (opcode == OP_IN) ? S_T0 : S_T4;
         S_T4: state_d = S_T5;
         S_T5: state_d = (opcode == OP_LD || opcode == OP_ST || opcode == OP_BR) ? S_T6 : S_T0;
         S_T6: state_d = (opcode == OP_BR) ? S_T0 : S_T7;
         S_T7: state_d = S_T0;
         S_HALT:    state_d = S_HALT;
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_IDLE;
      endcase
   end

   // strobe decode from state and opcode
   always_comb begin
      in_en   = '0;
      out_en  = '0;
      gsel    = '0;
      Read    = 1'b0;
      write   = 1'b0;
      IncPC   = 1'b0;
      Run     = 1'b1;
      step    = 4'd15;
      illegal = 1'b0;
      case (state_q)
         S_T0: begin
            step = 4'd0;
            out_en[OUT_PC] = 1'b1; in_en[IN_MAR] = 1'b1; in_en[IN_Z] = 1'b1; IncPC = 1'b1;
         end
         S_T1: begin
            step = 4'd1;
            out_en[OUT_ZLO] = 1'b1; in_en[IN_PC] = 1'b1; in_en[IN_MDR] = 1'b1; Read = 1'b1;
         end
         S_T2: begin
            step = 4'd2;
            out_en[OUT_MDR] = 1'b1; in_en[IN_IR] = 1'b1;
         end
         S_T3: begin
            step = 4'd3;
            if (opcode == OP_BR) begin
               gsel[G_RA] = 1'b1; gsel[G_ROUT] = 1'b1; in_en[IN_CON] = 1'b1;
            end else if (opcode == OP_IN) begin
               out_en[OUT_INP] = 1'b1; gsel[G_RA] = 1'b1; gsel[G_RIN] = 1'b1;
            end else if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI) begin
               gsel[G_RB] = 1'b1; gsel[G_ROUT] = 1'b1; in_en[IN_Y] = 1'b1;
            end else begin
               // ld / ldi / st: base register via BAout (r0 reads as zero)
               gsel[G_RB] = 1'b1; gsel[G_BA] = 1'b1; in_en[IN_Y] = 1'b1;
            end
         end
         S_T4: begin
            step = 4'd4;
            if (opcode == OP_BR) begin
               out_en[OUT_PC] = 1'b1; in_en[IN_Y] = 1'b1;
            end else begin
               out_en[OUT_C] = 1'b1; in_en[IN_Z] = 1'b1;
            end
         end
         S_T5: begin
            step = 4'd5;
            if (opcode == OP_BR) begin
               out_en[OUT_C] = 1'b1; in_en[IN_Z] = 1'b1;
            end else if (opcode == OP_LD || opcode == OP_ST) begin
               out_en[OUT_ZLO] = 1'b1; in_en[IN_MAR] = 1'b1;
            end else begin
               out_en[OUT_ZLO] = 1'b1; gsel[G_RA] = 1'b1; gsel[G_RIN] = 1'b1;
            end
         end
         S_T6: begin
            step = 4'd6;
            if (opcode == OP_BR) begin
               // branch taken only if CON is set in this step
               out_en[OUT_ZLO] = CON; in_en[IN_PC] = CON;
            end else if (opcode == OP_ST) begin
               gsel[G_RA] = 1'b1; gsel[G_ROUT] = 1'b1; in_en[IN_MDR] = 1'b1;
            end else begin
               Read = 1'b1; in_en[IN_MDR] = 1'b1;
            end
         end
         S_T7: begin
            step = 4'd7;
            if (opcode == OP_ST) begin
               write = 1'b1;
            end else begin
               out_en[OUT_MDR] = 1'b1; gsel[G_RA] = 1'b1; gsel[G_RIN] = 1'b1;
            end
         end
         S_HALT: Run = 1'b0;
         S_ILLEGAL: begin
            Run = 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal = 1'b1;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [31:0] IR;
   logic        CON;
   logic        Stop;
   logic [9:0]  in_en, out_en;
   logic [5:0]  gsel;
   logic        Read, write, IncPC, Run, illegal;
   logic [3:0]  step;

   int errors = 0;
   int checks = 0;

   control_sequencer dut (
      .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .Stop(Stop),
      .in_en(in_en), .out_en(out_en), .gsel(gsel),
      .Read(Read), .write(write), .IncPC(IncPC),
      .Run(Run), .step(step), .illegal(illegal)
   );

   always #5 Clock = ~Clock;

   localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;
   localparam logic [4:0] ADDI = 5'b01100, ANDI = 5'b01101, ORI = 5'b01110;
   localparam logic [4:0] BR = 5'b10010, INP = 5'b10101, NOP = 5'b11001, HLT = 5'b11010;

   localparam logic [9:0] I_PC = 10'h080, I_MDR = 10'h040, I_Z = 10'h010, I_Y = 10'h008;
   localparam logic [9:0] I_MAR = 10'h004, I_IR = 10'h002, I_CON = 10'h001;
   localparam logic [9:0] O_ZLO = 10'h040, O_PC = 10'h020, O_MDR = 10'h010, O_INP = 10'h008, O_C = 10'h002;
   localparam logic [5:0] G_RA = 6'h20, G_RB = 6'h10, G_RIN = 6'h04, G_ROUT = 6'h02, G_BA = 6'h01;

   // one expected cycle of the microprogram
   typedef struct packed {
      logic [3:0] st;
      logic [9:0] ie;
      logic [9:0] oe;
      logic [5:0] gs;
      logic       rd, wr, inc, run, ill;
   } exp_t;

   exp_t exp_q[$];

   wire [34:0] act = {step, in_en, out_en, gsel, Read, write, IncPC, Run, illegal};

   function automatic exp_t mk(input logic [3:0] s, input logic [9:0] ie, input logic [9:0] oe,
                               input logic [5:0] gs, input logic rd, input logic wr, input logic inc);
      exp_t e;
      e.st = s; e.ie = ie; e.oe = oe; e.gs = gs;
      e.rd = rd; e.wr = wr; e.inc = inc; e.run = 1'b1; e.ill = 1'b0;
      return e;
   endfunction

   function automatic exp_t stopped(input logic ill);
      exp_t e;
      e = mk(4'd15, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      e.run = 1'b0; e.ill = ill;
      return e;
   endfunction

   function automatic bit listed(input logic [4:0] op);
      return op inside {LD, LDI, ST, ADDI, ANDI, ORI, BR, INP, NOP, HLT};
   endfunction

   // expand one instruction into its expected per-cycle strobe list
   task automatic build_exp(input logic [4:0] op, input logic con);
      exp_q.delete();
      exp_q.push_back(mk(4'd0, I_MAR | I_Z, O_PC, '0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(4'd1, I_PC | I_MDR, O_ZLO, '0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd2, I_IR, O_MDR, '0, 1'b0, 1'b0, 1'b0));
      if (op == LD || op == LDI || op == ST) begin
         exp_q.push_back(mk(4'd3, I_Y, '0, G_RB | G_BA, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(mk(4'd4, I_Z, O_C, '0, 1'b0, 1'b0, 1'b0));
         if (op == LDI)
            exp_q.push_back(mk(4'd5, '0, O_ZLO, G_RA | G_RIN, 1'b0, 1'b0, 1'b0));
         else
            exp_q.push_back(mk(4'd5, I_MAR, O_ZLO, '0, 1'b0, 1'b0, 1'b0));
         if (op == LD) begin
            exp_q.push_back(mk(4'd6, I_MDR, '0, '0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(4'd7, '0, O_MDR, G_RA | G_RIN, 1'b0, 1'b0, 1'b0));
         end else if (op == ST) begin
            exp_q.push_back(mk(4'd6, I_MDR, '0, G_RA | G_ROUT, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(4'd7, '0, '0, '0, 1'b0, 1'b1, 1'b0));
         end
      end else if (op == ADDI || op == ANDI || op == ORI) begin
         exp_q.push_back(mk(4'd3, I_Y, '0, G_RB | G_ROUT, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(mk(4'd4, I_Z, O_C, '0, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(mk(4'd5, '0, O_ZLO, G_RA | G_RIN, 1'b0, 1'b0, 1'b0));
      end else if (op == BR) begin
         exp_q.push_back(mk(4'd3, I_CON, '0, G_RA | G_ROUT, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(mk(4'd4, I_Y, O_PC, '0, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(mk(4'd5, I_Z, O_C, '0, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(mk(4'd6, con ? I_PC : 10'h000, con ? O_ZLO : 10'h000, '0, 1'b0, 1'b0, 1'b0));
      end else if (op == INP) begin
         exp_q.push_back(mk(4'd3, '0, O_INP, G_RA | G_RIN, 1'b0, 1'b0, 1'b0));
      end else if (op == HLT) begin
         repeat (3) exp_q.push_back(stopped(1'b0));
      end else if (!listed(op)) begin
`ifdef ILLEGAL_TRAP_EN
         repeat (3) exp_q.push_back(stopped(1'b1));
`endif
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // run one instruction from T0, checking every cycle against the expansion
   task automatic run_instr(input logic [4:0] op, input logic con);
      build_exp(op, con);
      IR = {op, 27'($urandom)};
      for (int i = 0; i < exp_q.size(); i++) begin
         // br: drive the opposite CON before T6 so early sampling is caught
         if (op == BR) CON = (exp_q[i].st == 4'd6) ? con : ~con;
         else          CON = 1'($urandom);
         #1;
         checks++;
         if (act !== exp_q[i]) begin
            errors++;
            $display("FAIL op%b cyc%0d: got %h required %h", op, i, act, exp_q[i]);
         end
         checks++;
         if ((Read && write) || $countones(out_en) > 1) begin
            errors++;
            $display("FAIL exclusivity op%b cyc%0d: Read=%b write=%b out_en=%b", op, i, Read, write, out_en);
         end
         tick();
      end
   endtask

   // reset for one cycle, check IDLE, then advance to T0
   task automatic do_reset(input string tag);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      #1;
      checks++;
      if ({step, in_en, out_en, gsel, Read, write, IncPC, Run, illegal} !==
          {4'd15, 10'h0, 10'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL %s idle: got %h required step=f strobes=0 Run=1", tag, act);
      end
      tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1; Stop = 1'b0; CON = 1'b0; IR = {NOP, 27'h0};
      tick(); tick();
      Reset = 1'b0;
      #1;
      checks++;
      if (act !== {4'd15, 10'h0, 10'h0, 6'h0, 5'b00010}) begin
         errors++;
         $display("FAIL reset_idle: got %h required idle", act);
      end
      tick();
      checks++;
      if (step !== 4'd0 || out_en !== O_PC || in_en !== (I_MAR | I_Z) || IncPC !== 1'b1) begin
         errors++;
         $display("FAIL reset_t0: step=%0d out_en=%b in_en=%b IncPC=%b required 0/%b/%b/1",
                  step, out_en, in_en, IncPC, O_PC, I_MAR | I_Z);
      end
   endtask

   task automatic test_ld();  run_instr(LD, 1'b0); endtask
   task automatic test_st();  run_instr(ST, 1'b1); endtask
   task automatic test_br();
      run_instr(BR, 1'b0);
      run_instr(BR, 1'b1);
   endtask

   task automatic test_stop();
      IR = {NOP, 27'h0};
      Stop = 1'b1;
      #1;
      checks++;
      if (step !== 4'd0 || IncPC !== 1'b1) begin
         errors++;
         $display("FAIL stop_t0: step=%0d IncPC=%b required 0/1", step, IncPC);
      end
      tick();
      Stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (act !== stopped(1'b0)) begin
            errors++;
            $display("FAIL stop_halt cyc%0d: got %h required %h", i, act, stopped(1'b0));
         end
         tick();
      end
      do_reset("stop");
   endtask

   task automatic test_reset_mid_ld();
      build_exp(LD, 1'b0);
      IR = {LD, 27'h1234};
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (step !== 4'd4) begin
         errors++;
         $display("FAIL midld_t4: step=%0d required 4", step);
      end
      do_reset("midld");
   endtask

   task automatic test_halt_opcode();
      run_instr(HLT, 1'b0);
      do_reset("halt");
   endtask

   task automatic test_illegal();
      run_instr(5'b11111, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      do_reset("illegal");
`else
      checks++;
      if (step !== 4'd0) begin
         errors++;
         $display("FAIL illegal_nop: step=%0d required 0", step);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [4:0] op;
      for (int n = 0; n < 40; n++) begin
         op = 5'($urandom);
         if (n % 2 == 0) begin
            case ($urandom_range(0, 8))
               0: op = LD;   1: op = LDI; 2: op = ST;  3: op = ADDI; 4: op = ANDI;
               5: op = ORI;  6: op = BR;  7: op = INP; default: op = NOP;
            endcase
         end
         run_instr(op, 1'($urandom));
`ifdef ILLEGAL_TRAP_EN
         if (op == HLT || !listed(op)) do_reset("rand");
`else
         if (op == HLT) do_reset("rand");
`endif
      end
   endtask

   initial begin
      test_reset();
      test_ld();
      test_br();
      test_st();
      test_stop();
      test_reset_mid_ld();
      test_halt_opcode();
      test_illegal();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
